// File: rtl/addsub_serial_if.sv
// Start/busy/done handshake and operand/result bundle for addsub_serial.
interface addsub_serial_if #(
  parameter int unsigned N = 16
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   op;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         ovf;
  logic         cout;
  logic         zero;
  logic         neg;

  modport master (
    output start, a, b, op,
    input  busy, done, s, ovf, cout, zero, neg
  );

  modport slave (
    input  start, a, b, op,
    output busy, done, s, ovf, cout, zero, neg
  );
endinterface

// File: rtl/addsub_serial.sv
// Multicycle two's-complement add/sub, D bits per clock, LS chunk first,
// with optional saturation and registered result flags.
module addsub_serial #(
  parameter int unsigned N = 16,
  parameter int unsigned D = 4
) (
  input logic            clk,
  input logic            rst,
  addsub_serial_if.slave bus
);
  localparam int unsigned M  = N / D;
  localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_r, b_r, r;
  logic          c, sat_r;
  logic          load, last;
  int unsigned   base;
  logic [D:0]    csum;
  logic [N-1:0]  raw, res;
  logic          cmsb, ovf_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        load     = 1'b1;
        state_nx = RUN;
      end
      RUN: if (cnt == CW'(M - 1)) begin
        last     = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.busy = (state == RUN);

  // Carry into the MSB is recovered from the MSB sum bit, so the chunk adder
  // stays D+1 bits wide even on the last chunk.
  always_comb begin
    base   = 32'(cnt) * D;
    csum   = {1'b0, a_r[base +: D]} + {1'b0, b_r[base +: D]} + {{D{1'b0}}, c};
    raw    = r;
    raw[base +: D] = csum[D-1:0];
    cmsb   = csum[D-1] ^ a_r[N-1] ^ b_r[N-1];
    ovf_nx = cmsb ^ csum[D];
    res    = raw;
    if (sat_r && ovf_nx)
      res = a_r[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      c        <= 1'b0;
      sat_r    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      r        <= '0;
      bus.done <= 1'b0;
      bus.s    <= '0;
      bus.ovf  <= 1'b0;
      bus.cout <= 1'b0;
      bus.zero <= 1'b0;
      bus.neg  <= 1'b0;
    end else begin
      bus.done <= last;
      if (load) begin
        a_r   <= bus.a;
        b_r   <= bus.op[0] ? ~bus.b : bus.b;
        c     <= bus.op[0];
        sat_r <= bus.op[1];
        cnt   <= '0;
      end else if (state == RUN) begin
        r   <= raw;
        c   <= csum[D];
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        bus.s    <= res;
        bus.ovf  <= ovf_nx;
        bus.cout <= csum[D];
        bus.zero <= (res == '0);
        bus.neg  <= res[N-1];
      end
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial at N=8, D=2: directed handshake/boundary cases plus
// random operations checked against a signed-arithmetic reference model.
module tb_addsub_serial;
  localparam int unsigned N = 8;
  localparam int unsigned D = 2;
  localparam int unsigned M = N / D;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  addsub_serial_if #(.N(N)) bus ();
  addsub_serial #(.N(N), .D(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {zero, neg, ovf, cout, s[7:0]}.
  function automatic logic [11:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] o);
    int       sx, sy, exact;
    logic     ov, co;
    logic [7:0] r;
    sx    = $signed(x);
    sy    = $signed(y);
    exact = o[0] ? sx - sy : sx + sy;
    co    = o[0] ? (x >= y) : ((32'(x) + 32'(y)) > 255);
    ov    = (exact > 127) || (exact < -128);
    r     = 8'(exact);
    if (o[1] && ov) r = (sx >= 0) ? 8'h7F : 8'h80;
    return {r == 8'h00, r[7], ov, co, r};
  endfunction

  task automatic check_result(input string tag, input logic [7:0] x, input logic [7:0] y,
                              input logic [1:0] o);
    logic [11:0] e;
    e = model(x, y, o);
    chk({tag, ".s"},    32'(bus.s),    32'(e[7:0]));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(e[8]));
    chk({tag, ".ovf"},  32'(bus.ovf),  32'(e[9]));
    chk({tag, ".neg"},  32'(bus.neg),  32'(e[10]));
    chk({tag, ".zero"}, 32'(bus.zero), 32'(e[11]));
  endtask

  // Start one op, check busy for M cycles, done in cycle M+1, then result.
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [1:0] o);
    @(negedge clk);
    bus.start = 1'b1; bus.a = x; bus.b = y; bus.op = o;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 2'($urandom);
    for (int i = 0; i < int'(M); i++) begin
      chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
      chk({tag, ".early_done"}, 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, ".done"}, 32'(bus.done), 32'd1);
    check_result(tag, x, y, o);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.s",    32'(bus.s),    0);
    chk("rst.ovf",  32'(bus.ovf),  0);
    chk("rst.cout", 32'(bus.cout), 0);
    chk("rst.zero", 32'(bus.zero), 0);
    chk("rst.neg",  32'(bus.neg),  0);
    rst = 1'b0;

    run_op("add_ovf", 8'h7F, 8'h01, 2'b00);
    chk("add_ovf.s_const", 32'(bus.s), 32'h80);
    chk("add_ovf.ovf_const", 32'(bus.ovf), 1);
    chk("add_ovf.cout_const", 32'(bus.cout), 0);
    run_op("sadd_ovf", 8'h7F, 8'h01, 2'b10);
    chk("sadd_ovf.s_const", 32'(bus.s), 32'h7F);
    run_op("sub_ovf", 8'h80, 8'h01, 2'b01);
    chk("sub_ovf.s_const", 32'(bus.s), 32'h7F);
    chk("sub_ovf.cout_const", 32'(bus.cout), 1);
    run_op("ssub_ovf", 8'h80, 8'h01, 2'b11);
    chk("ssub_ovf.s_const", 32'(bus.s), 32'h80);
    run_op("sub_zero", 8'h05, 8'h05, 2'b01);
    chk("sub_zero.zero_const", 32'(bus.zero), 1);

    // start pulsed while busy must be ignored
    @(negedge clk); bus.start = 1'b1; bus.a = 8'h03; bus.b = 8'h04; bus.op = 2'b00;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.op = 2'b01;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ign.done", 32'(bus.done), 1);
    check_result("ign", 8'h03, 8'h04, 2'b00);
    @(negedge clk);
    chk("ign.no_queue", 32'(bus.busy), 0);
    chk("ign.done_pulse", 32'(bus.done), 0);

    // start held high across done: second op accepted in the done cycle
    @(negedge clk); bus.start = 1'b1; bus.a = 8'h40; bus.b = 8'h30; bus.op = 2'b00;
    @(negedge clk); bus.a = 8'h90; bus.b = 8'h20; bus.op = 2'b11;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("hold.done1", 32'(bus.done), 1);
    check_result("hold1", 8'h40, 8'h30, 2'b00);
    @(negedge clk); bus.start = 1'b0;
    chk("hold.busy2", 32'(bus.busy), 1);
    chk("hold.done_pulse", 32'(bus.done), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold.busy2", 32'(bus.busy), 1);
      chk("hold.early_done2", 32'(bus.done), 0);
    end
    @(negedge clk);
    chk("hold.done2", 32'(bus.done), 1);
    check_result("hold2", 8'h90, 8'h20, 2'b11);

    // reset in the 2nd RUN cycle aborts the op
    run_op("pre_rst", 8'h7F, 8'h01, 2'b00);
    @(negedge clk); bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.op = 2'b00;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort.busy", 32'(bus.busy), 0);
    chk("abort.s", 32'(bus.s), 0);
    chk("abort.ovf", 32'(bus.ovf), 0);
    for (int i = 0; i < 6; i++) begin
      chk("abort.no_done", 32'(bus.done), 0);
      @(negedge clk);
    end
    chk("abort.s_hold", 32'(bus.s), 0);
    run_op("post_rst", 8'h10, 8'h20, 2'b00);

    for (int i = 0; i < 40; i++)
      run_op("rand", 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
